// File: rtl/frame_buffer_ctrl_mb.sv
// Multi-buffer frame-buffer controller: rotates writer and reader over NUM_BUFFERS buffers.
// Optional FB_STATS_EN adds saturating drop/repeat counters.
module frame_buffer_ctrl_mb #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 16,
  parameter int                    NUM_BUFFERS  = 3,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter logic [ADDR_WIDTH-1:0] FRAME_STRIDE = ADDR_WIDTH'(32'h0010_0000),
  parameter int                    ADDR_STEP    = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [15:0]           resolution_width_i,
  input  logic [15:0]           resolution_depth_i,
  input  logic                  empty_i,
  input  logic                  full_i,
  output logic                  wr_o,
  output logic                  rd_o,
  output logic [ADDR_WIDTH-1:0] addr_wr_o,
  output logic [ADDR_WIDTH-1:0] addr_rd_o,
  output logic [1:0]            wr_buf_o,
  output logic [1:0]            rd_buf_o,
  output logic                  wr_frame_done_o,
  output logic                  rd_frame_done_o,
  output logic                  frame_drop_o
`ifdef FB_STATS_EN
  ,
  output logic [15:0]           drop_count_o,
  output logic [15:0]           repeat_count_o
`endif
);

  if (NUM_BUFFERS < 2 || NUM_BUFFERS > 4 || DATA_WIDTH < 1) begin : g_bad_param
    $error("frame_buffer_ctrl_mb: NUM_BUFFERS must be 2..4 and DATA_WIDTH positive");
  end

  typedef enum logic [1:0] {W_IDLE, W_WRITE, W_WAIT} wr_state_t;
  typedef enum logic       {R_IDLE, R_READ} rd_state_t;

  wr_state_t   wr_state;
  rd_state_t   rd_state;
  logic [1:0]  wr_buf, rd_buf, latest, rd_buf_nxt, wr_free;
  logic [31:0] wr_size, rd_size, wr_pix, rd_pix, cur_size;
  logic        latest_valid, latest_unread;
  logic        wr_last, rd_last, rd_take, wr_found;

  // First buffer after cur (mod N) that differs from excl; MSB flags success.
  function automatic logic [2:0] find_free(input logic [1:0] cur, input logic [1:0] excl);
    logic [2:0] res;
    logic [1:0] cand;
    res  = '0;
    cand = cur;
    for (int k = 1; k < NUM_BUFFERS; k++) begin
      cand = (cand == 2'(NUM_BUFFERS - 1)) ? 2'd0 : cand + 2'd1;
      if (!res[2] && cand != excl) res = {1'b1, cand};
    end
    return res;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] buf_addr(input logic [1:0] b, input logic [31:0] pix);
    return BASE_ADDR + ADDR_WIDTH'(b) * FRAME_STRIDE + ADDR_WIDTH'(pix) * ADDR_WIDTH'(ADDR_STEP);
  endfunction

  assign cur_size = 32'(resolution_width_i) * 32'(resolution_depth_i);

  assign wr_o    = (wr_state == W_WRITE) & ~empty_i;
  assign rd_o    = (rd_state == R_READ) & ~full_i;
  assign wr_last = wr_o & (wr_pix == wr_size - 32'd1);
  assign rd_last = rd_o & (rd_pix == rd_size - 32'd1);

  // Reader grabs the latest frame on start-up or at frame end if a newer one is waiting;
  // it always sees latest/latest_unread as they were before any same-cycle write completion.
  assign rd_take    = ((rd_state == R_IDLE) & latest_valid & (cur_size != 32'd0)) |
                      (rd_last & latest_unread);
  assign rd_buf_nxt = rd_take ? latest : rd_buf;
  assign {wr_found, wr_free} = find_free(wr_buf, rd_buf_nxt);

  assign addr_wr_o       = buf_addr(wr_buf, wr_pix);
  assign addr_rd_o       = buf_addr(rd_buf, rd_pix);
  assign wr_buf_o        = wr_buf;
  assign rd_buf_o        = rd_buf;
  assign wr_frame_done_o = wr_last;
  assign rd_frame_done_o = rd_last;
  assign frame_drop_o    = wr_last & latest_unread & ~rd_take;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      latest        <= 2'd0;
      latest_valid  <= 1'b0;
      latest_unread <= 1'b0;
    end else if (wr_last) begin
      latest        <= wr_buf;
      latest_valid  <= 1'b1;
      latest_unread <= 1'b1;
    end else if (rd_take) begin
      latest_unread <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_state <= W_IDLE;
      wr_buf   <= 2'd0;
      wr_pix   <= 32'd0;
      wr_size  <= 32'd0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (cur_size != 32'd0) begin
            wr_state <= W_WRITE;
            wr_size  <= cur_size;
            wr_pix   <= 32'd0;
          end
        end
        W_WRITE: begin
          if (wr_last) begin
            wr_pix <= 32'd0;
            if (wr_found) begin
              wr_buf   <= wr_free;
              wr_size  <= cur_size;
              wr_state <= (cur_size != 32'd0) ? W_WRITE : W_IDLE;
            end else begin
              wr_state <= W_WAIT;
            end
          end else if (wr_o) begin
            wr_pix <= wr_pix + 32'd1;
          end
        end
        W_WAIT: begin
          // wr_buf still names the just-finished frame, so find_free skips it.
          if (wr_found) begin
            wr_buf   <= wr_free;
            wr_size  <= cur_size;
            wr_state <= (cur_size != 32'd0) ? W_WRITE : W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_state <= R_IDLE;
      rd_buf   <= 2'd0;
      rd_pix   <= 32'd0;
      rd_size  <= 32'd0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (rd_take) begin
            rd_state <= R_READ;
            rd_buf   <= latest;
            rd_size  <= cur_size;
            rd_pix   <= 32'd0;
          end
        end
        R_READ: begin
          if (rd_last) begin
            rd_pix   <= 32'd0;
            rd_buf   <= rd_buf_nxt;
            rd_size  <= cur_size;
            rd_state <= (cur_size != 32'd0) ? R_READ : R_IDLE;
          end else if (rd_o) begin
            rd_pix <= rd_pix + 32'd1;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

`ifdef FB_STATS_EN
  logic rd_repeat;
  assign rd_repeat = rd_last & ~latest_unread;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      drop_count_o   <= 16'd0;
      repeat_count_o <= 16'd0;
    end else begin
      if (frame_drop_o && drop_count_o != 16'hFFFF) drop_count_o <= drop_count_o + 16'd1;
      if (rd_repeat && repeat_count_o != 16'hFFFF) repeat_count_o <= repeat_count_o + 16'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_frame_buffer_ctrl_mb.sv
// Directed bench for frame_buffer_ctrl_mb: a triple-buffer instance (a) and a double-buffer instance (b)
// share stimulus; W=8, D=4 gives 32-pixel frames, stride 'h100.
module tb_frame_buffer_ctrl_mb;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_i;
  logic [15:0] w, d;
  logic        empty, full;

  logic        wr_a, rd_a, wdone_a, rdone_a, drop_a;
  logic [31:0] awr_a, ard_a;
  logic [1:0]  wbuf_a, rbuf_a;
  logic        wr_b, rd_b, wdone_b, rdone_b, drop_b;
  logic [31:0] awr_b, ard_b;
  logic [1:0]  wbuf_b, rbuf_b;
`ifdef FB_STATS_EN
  logic [15:0] dcnt_a, rcnt_a, dcnt_b, rcnt_b;
`endif

  frame_buffer_ctrl_mb #(.ADDR_WIDTH(32), .DATA_WIDTH(16), .NUM_BUFFERS(3), .BASE_ADDR(32'h0),
                         .FRAME_STRIDE(32'h100), .ADDR_STEP(1)) dut_a (
    .clk_i(clk), .reset_i(reset_i), .resolution_width_i(w), .resolution_depth_i(d),
    .empty_i(empty), .full_i(full), .wr_o(wr_a), .rd_o(rd_a), .addr_wr_o(awr_a), .addr_rd_o(ard_a),
    .wr_buf_o(wbuf_a), .rd_buf_o(rbuf_a), .wr_frame_done_o(wdone_a), .rd_frame_done_o(rdone_a),
    .frame_drop_o(drop_a)
`ifdef FB_STATS_EN
    , .drop_count_o(dcnt_a), .repeat_count_o(rcnt_a)
`endif
  );

  frame_buffer_ctrl_mb #(.ADDR_WIDTH(32), .DATA_WIDTH(16), .NUM_BUFFERS(2), .BASE_ADDR(32'h0),
                         .FRAME_STRIDE(32'h100), .ADDR_STEP(1)) dut_b (
    .clk_i(clk), .reset_i(reset_i), .resolution_width_i(w), .resolution_depth_i(d),
    .empty_i(empty), .full_i(full), .wr_o(wr_b), .rd_o(rd_b), .addr_wr_o(awr_b), .addr_rd_o(ard_b),
    .wr_buf_o(wbuf_b), .rd_buf_o(rbuf_b), .wr_frame_done_o(wdone_b), .rd_frame_done_o(rdone_b),
    .frame_drop_o(drop_b)
`ifdef FB_STATS_EN
    , .drop_count_o(dcnt_b), .repeat_count_o(rcnt_b)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  // Sample point is 2 time units after the rising edge; cycle k means just after edge E0+k.
  task automatic adv();
    @(posedge clk);
    #2;
    cycle++;
  endtask

  task automatic go_to(input int n);
    while (cycle < n) adv();
  endtask

  task automatic restart(input logic e, input logic f);
    reset_i = 1'b1;
    empty   = e;
    full    = f;
    adv();
    adv();
    reset_i = 1'b0;
    cycle   = -1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    w = 16'd8; d = 16'd4;

    // Reset state and basic write/read rotation
    reset_i = 1'b1; empty = 1'b0; full = 1'b0;
    adv(); adv();
    chk("rst_wr", {31'd0, wr_a}, 32'd0);
    chk("rst_rd", {31'd0, rd_a}, 32'd0);
    chk("rst_awr", awr_a, 32'd0);
    chk("rst_ard", ard_a, 32'd0);
    chk("rst_bufs", {28'd0, wbuf_a, rbuf_a}, 32'd0);
    chk("rst_pulses", {29'd0, wdone_a, rdone_a, drop_a}, 32'd0);
    reset_i = 1'b0; cycle = -1;
    go_to(0);
    chk("t1_wr0", {31'd0, wr_a}, 32'd1);
    chk("t1_awr0", awr_a, 32'd0);
    go_to(31);
    chk("t1_awr31", awr_a, 32'd31);
    chk("t1_wdone31", {31'd0, wdone_a}, 32'd1);
    chk("t1_drop31", {31'd0, drop_a}, 32'd0);
    go_to(32);
    chk("t1_awr32", awr_a, 32'h100);
    chk("t1_wbuf32", {30'd0, wbuf_a}, 32'd1);
    chk("t1_rd32", {31'd0, rd_a}, 32'd0);
    go_to(33);
    chk("t1_rd33", {31'd0, rd_a}, 32'd1);
    chk("t1_ard33", ard_a, 32'd0);
    go_to(63);
    chk("t1_awr63", awr_a, 32'h11F);
    go_to(64);
    chk("t1_awr64", awr_a, 32'h200);
    chk("t1_ard64", ard_a, 32'd31);
    chk("t1_rdone64", {31'd0, rdone_a}, 32'd1);
    go_to(65);
    chk("t1_rbuf65", {30'd0, rbuf_a}, 32'd1);
    chk("t1_ard65", ard_a, 32'h100);

    // Stalls: empty freezes the writer, full freezes the reader
    restart(1'b0, 1'b0);
    go_to(10);
    empty = 1'b1; #1;
    chk("t2_wr_stall", {31'd0, wr_a}, 32'd0);
    chk("t2_awr_stall", awr_a, 32'd10);
    go_to(15);
    chk("t2_awr_frozen", awr_a, 32'd10);
    empty = 1'b0; #1;
    chk("t2_wr_resume", {31'd0, wr_a}, 32'd1);
    chk("t2_awr_resume", awr_a, 32'd10);
    go_to(16);
    chk("t2_awr_next", awr_a, 32'd11);
    go_to(45);
    chk("t2_ard45", ard_a, 32'd7);
    full = 1'b1; #1;
    chk("t2_rd_stall", {31'd0, rd_a}, 32'd0);
    go_to(50);
    chk("t2_ard_frozen", ard_a, 32'd7);
    full = 1'b0; #1;
    chk("t2_rd_resume", {31'd0, rd_a}, 32'd1);
    chk("t2_ard_resume", ard_a, 32'd7);
    go_to(51);
    chk("t2_ard_next", ard_a, 32'd8);

    // Simultaneous write-done and read-done
    restart(1'b0, 1'b1);
    go_to(64);
    full = 1'b0;
    go_to(95);
    chk("t5_wdone", {31'd0, wdone_a}, 32'd1);
    chk("t5_rdone", {31'd0, rdone_a}, 32'd1);
    chk("t5_nodrop", {31'd0, drop_a}, 32'd0);
    go_to(96);
    chk("t5_rbuf_old_latest", {30'd0, rbuf_a}, 32'd1);
    chk("t5_wbuf", {30'd0, wbuf_a}, 32'd0);
    chk("t5_ard", ard_a, 32'h100);
    go_to(127);
    chk("t5_nodrop2", {31'd0, drop_a}, 32'd0);
    go_to(128);
    chk("t5_rbuf_unread", {30'd0, rbuf_a}, 32'd2);
    chk("t5_wbuf2", {30'd0, wbuf_a}, 32'd1);

    // Double buffering: writer waits for the reader to release a buffer
    restart(1'b0, 1'b1);
    go_to(63);
    chk("t4_wdone", {31'd0, wdone_b}, 32'd1);
    go_to(64);
    chk("t4_wait_wr", {31'd0, wr_b}, 32'd0);
    chk("t4_wait_wbuf", {30'd0, wbuf_b}, 32'd1);
    go_to(70);
    chk("t4_still_wait", {31'd0, wr_b}, 32'd0);
    full = 1'b0;
    go_to(101);
    chk("t4_rdone", {31'd0, rdone_b}, 32'd1);
    chk("t4_wr_off", {31'd0, wr_b}, 32'd0);
    go_to(102);
    chk("t4_wr_resume", {31'd0, wr_b}, 32'd1);
    chk("t4_awr", awr_b, 32'h000);
    chk("t4_wbuf", {30'd0, wbuf_b}, 32'd0);
    chk("t4_rbuf", {30'd0, rbuf_b}, 32'd1);
    chk("t4_ard", ard_b, 32'h100);

    // Reader stalled for good: unread frames get replaced
    restart(1'b0, 1'b1);
    go_to(63);
    chk("t3_drop_f2", {31'd0, drop_a}, 32'd0);
    go_to(64);
    chk("t3_wbuf64", {30'd0, wbuf_a}, 32'd2);
    go_to(95);
    chk("t3_drop_f3", {31'd0, drop_a}, 32'd1);
    go_to(96);
    chk("t3_wbuf96", {30'd0, wbuf_a}, 32'd1);
    go_to(127);
    chk("t3_drop_f4", {31'd0, drop_a}, 32'd1);
    go_to(128);
    chk("t3_wbuf128", {30'd0, wbuf_a}, 32'd2);
    chk("t3_rbuf128", {30'd0, rbuf_a}, 32'd0);
    chk("t3_rd_off", {31'd0, rd_a}, 32'd0);
`ifdef FB_STATS_EN
    chk("t3_drop_count", {16'd0, dcnt_a}, 32'd2);
    chk("t3_repeat_count", {16'd0, rcnt_a}, 32'd0);
`endif

    // Reset mid-frame, then zero width keeps both sides idle
    go_to(140);
    chk("t6_active", {31'd0, wr_a}, 32'd1);
    reset_i = 1'b1;
    adv();
    chk("t6_rst_wr", {31'd0, wr_a}, 32'd0);
    chk("t6_rst_awr", awr_a, 32'd0);
    chk("t6_rst_bufs", {28'd0, wbuf_a, rbuf_a}, 32'd0);
`ifdef FB_STATS_EN
    chk("t6_rst_drop_count", {16'd0, dcnt_a}, 32'd0);
`endif
    w = 16'd0; full = 1'b0;
    reset_i = 1'b0;
    for (int i = 0; i < 6; i++) adv();
    chk("t6_w0_wr", {30'd0, wr_a, wr_b}, 32'd0);
    chk("t6_w0_rd", {30'd0, rd_a, rd_b}, 32'd0);
    chk("t6_w0_awr", awr_a, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
